// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk geometry and its sanity check.
package adder_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The carry chain is cut into equal chunks, so the width must divide evenly.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CW-bit combinational ripple adder; also exposes the carry into its MSB so the
// last stage can derive signed overflow.
module adder_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic [CW:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < CW; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[CW];
  assign cmsb = carry[CW-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit chunk of the carry chain
// per stage, all stages advancing together under a single global enable.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("adder_pipe: WIDTH must be a positive multiple of STAGES");
  end

  // Operands ride along with the partial sum; upper chunks are consumed later.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             cmsb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t in_rec;
  stage_t st_q [STAGES];
  stage_t st_d [STAGES];
  logic   adv;

  assign adv      = !st_q[STAGES-1].valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + ~borrow, so invert both B and the carry-in up front.
  always_comb begin
    in_rec       = '0;
    in_rec.valid = in_valid;
    in_rec.carry = sub ^ cin;
    in_rec.a     = a;
    in_rec.b     = sub ? ~b : b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t        prev;
    stage_t        nxt;
    logic [CW-1:0] chunk_sum;
    logic          chunk_cout;
    logic          chunk_cmsb;

    if (k == 0) begin : g_first
      assign prev = in_rec;
    end else begin : g_rest
      assign prev = st_q[k-1];
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a    (prev.a[k*CW +: CW]),
      .b    (prev.b[k*CW +: CW]),
      .cin  (prev.carry),
      .sum  (chunk_sum),
      .cout (chunk_cout),
      .cmsb (chunk_cmsb)
    );

    always_comb begin
      nxt                 = prev;
      nxt.s[k*CW +: CW]   = chunk_sum;
      nxt.carry           = chunk_cout;
      nxt.cmsb            = chunk_cmsb;
    end

    assign st_d[k] = nxt;
  end

  // Clearing the whole record, not just valid, keeps sum/cout/ovf at zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
    end
  end

  assign out_valid = st_q[STAGES-1].valid;
  assign sum       = st_q[STAGES-1].s;
  assign cout      = st_q[STAGES-1].carry;
  assign ovf       = st_q[STAGES-1].carry ^ st_q[STAGES-1].cmsb;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed checks of adder_pipe at 16/4 plus an exhaustive sweep of a 4/2 build.
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
  logic [15:0] a, b, sum;

  logic        w4_in_valid, w4_in_ready, w4_out_valid, w4_out_ready;
  logic        w4_cin, w4_sub, w4_cout, w4_ovf;
  logic [3:0]  w4_a, w4_b, w4_sum;

  int n_checks = 0;
  int n_fail   = 0;

  adder_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(4), .STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .a(w4_a), .b(w4_b), .cin(w4_cin), .sub(w4_sub), .out_valid(w4_out_valid),
    .out_ready(w4_out_ready), .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    in_valid = 1'b1;
    a        = vecs[i].a;
    b        = vecs[i].b;
    cin      = vecs[i].cin;
    sub      = vecs[i].sub;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent signed/unsigned reference for the 4-bit build: {cout, ovf, sum}.
  function automatic logic [5:0] refModel(input logic [3:0] x, input logic [3:0] y,
                                          input logic ci, input logic s);
    int ux, uy, sx, sy, r, sr;
    logic co, ov;
    logic [3:0] rs;
    ux = int'(x);
    uy = int'(y);
    sx = x[3] ? ux - 16 : ux;
    sy = y[3] ? uy - 16 : uy;
    if (!s) begin
      r  = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      co = (r > 15);
    end else begin
      r  = ux - uy - int'(ci);
      sr = sx - sy - int'(ci);
      co = (r >= 0);
    end
    ov = (sr > 7) || (sr < -8);
    rs = r[3:0];
    return {co, ov, rs};
  endfunction

  initial begin
    int sent, got, stall_left, stale, idx, rcv;
    bit stalled, acc;
    logic [5:0] expq [$];
    logic [5:0] expv;
    logic [9:0] op;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h1000, 16'h0FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    w4_in_valid = 1'b0; w4_out_ready = 1'b1; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_sub = 1'b0;
    step();
    step();
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_sum", sum, 16'h0000);
    checkOutput("rst_cout", cout, 1'b0);
    checkOutput("rst_ovf", ovf, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_w4_out_valid", w4_out_valid, 1'b0);
    rst_n = 1'b1;
    step();

    $display("[TB] single-beat latency and arithmetic");
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      applyStimulus(i);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        checkOutput($sformatf("lat%0d_early%0d", i, c), out_valid, 1'b0);
        step();
      end
      checkOutput($sformatf("lat%0d_valid", i), out_valid, 1'b1);
      checkOutput($sformatf("v%0d_sum", i), sum, vecs[i].s);
      checkOutput($sformatf("v%0d_cout", i), cout, vecs[i].co);
      checkOutput($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
      step();
      checkOutput($sformatf("lat%0d_drained", i), out_valid, 1'b0);
    end

    $display("[TB] back-to-back stream with 3-cycle stall");
    sent = 0; got = 0; stall_left = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (sent < 8) applyStimulus(sent);
      else in_valid = 1'b0;
      if (out_valid && !stalled) begin
        stalled    = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        checkOutput($sformatf("bp_stall_in_ready%0d", stall_left), in_ready, 1'b0);
        checkOutput($sformatf("bp_stall_sum%0d", stall_left), sum, vecs[got].s);
        checkOutput($sformatf("bp_stall_cout%0d", stall_left), cout, vecs[got].co);
        stall_left--;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (got < 8) begin
          checkOutput($sformatf("bp%0d_sum", got), sum, vecs[got].s);
          checkOutput($sformatf("bp%0d_cout", got), cout, vecs[got].co);
          checkOutput($sformatf("bp%0d_ovf", got), ovf, vecs[got].ov);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_sent", sent, 8);
    checkOutput("bp_received", got, 8);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale++;
      step();
    end
    checkOutput("bp_no_duplicates", stale, 0);

    $display("[TB] reset with beats in flight");
    for (int j = 0; j < 3; j++) begin
      applyStimulus(4 + j);
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("rst_mid_out_valid", out_valid, 1'b0);
    checkOutput("rst_mid_sum", sum, 16'h0000);
    checkOutput("rst_mid_in_ready", in_ready, 1'b1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) stale++;
      step();
    end
    checkOutput("rst_mid_stale", stale, 0);

    $display("[TB] reset during a stall");
    out_ready = 1'b0;
    applyStimulus(6);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) step();
    checkOutput("rst_stall_filled", out_valid, 1'b1);
    checkOutput("rst_stall_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    checkOutput("rst_stall_out_valid", out_valid, 1'b0);
    checkOutput("rst_stall_cout", cout, 1'b0);
    checkOutput("rst_stall_ovf", ovf, 1'b0);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale++;
      step();
    end
    checkOutput("rst_stall_stale", stale, 0);

    $display("[TB] exhaustive sweep of 4-bit build");
    idx = 0; rcv = 0;
    for (int cyc = 0; cyc < 5000 && rcv < 1024; cyc++) begin
      w4_in_valid = (idx < 1024);
      op = idx[9:0];
      w4_b   = op[3:0];
      w4_a   = op[7:4];
      w4_cin = op[8];
      w4_sub = op[9];
      w4_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = w4_in_valid && w4_in_ready;
      if (w4_out_valid && w4_out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("ex_unexpected_valid", w4_out_valid, 1'b0);
        end else begin
          expv = expq.pop_front();
          checkOutput($sformatf("ex_op%0d", rcv), {w4_cout, w4_ovf, w4_sum}, expv);
        end
        rcv++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        expq.push_back(refModel(w4_a, w4_b, w4_cin, w4_sub));
        idx++;
      end
    end
    w4_in_valid = 1'b0;
    checkOutput("ex_sent", idx, 1024);
    checkOutput("ex_received", rcv, 1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
